// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD IP: FSM state encoding, default widths
// and the helper that sizes the common power-of-two shift counter.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int CYCLE_W_DEF    = 16;

    // k never exceeds DATA_WIDTH-1, so $clog2(DATA_WIDTH) bits hold it.
    function automatic int shift_w(input int dw);
        return (dw > 2) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One Stein (binary GCD) iteration. Purely combinational: given the current
// (a, b, k) it yields the next (a, b, k), or flags completion together with
// the final value a << k.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int K_W        = shift_w(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [K_W-1:0]        k,
    output logic [DATA_WIDTH-1:0] a_next,
    output logic [DATA_WIDTH-1:0] b_next,
    output logic [K_W-1:0]        k_next,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] gcd_val
);

    // Priority-ordered step rules; the first matching rule wins.
    always_comb begin
        a_next  = a;
        b_next  = b;
        k_next  = k;
        done    = 1'b0;
        gcd_val = a << k;
        if (a == b) begin
            done = 1'b1;
        end else if (!a[0] && !b[0]) begin
            a_next = a >> 1;
            b_next = b >> 1;
            k_next = k + 1'b1;
        end else if (!a[0]) begin
            a_next = a >> 1;
        end else if (!b[0]) begin
            b_next = b >> 1;
        end else if (a > b) begin
            // Both odd and unequal: difference is positive and even.
            a_next = a - b;
        end else begin
            b_next = b - a;
        end
    end

endmodule

// File: rtl/gcd_core.sv
// Iterative binary GCD engine. Operands arrive on one valid/ready channel,
// the result and its iteration count leave on another.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds valid and data
// stable until that edge; ready may change freely. Input ready is high only
// while idle and out of reset; the result stays valid until accepted.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CYCLE_W    = CYCLE_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_gcd,
    output logic [CYCLE_W-1:0]    out_cycles,
    output logic                  busy
);

    localparam int K_W = shift_w(DATA_WIDTH);
    localparam logic [CYCLE_W-1:0] CNT_MAX = '1;

    gcd_state_t            state;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [K_W-1:0]        k_q;
    logic [CYCLE_W-1:0]    cnt_q;

    logic [DATA_WIDTH-1:0] a_nxt;
    logic [DATA_WIDTH-1:0] b_nxt;
    logic [K_W-1:0]        k_nxt;
    logic                  step_done;
    logic [DATA_WIDTH-1:0] gcd_val;
    logic [CYCLE_W-1:0]    cnt_inc;

    gcd_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .K_W        (K_W)
    ) u_step (
        .a       (a_q),
        .b       (b_q),
        .k       (k_q),
        .a_next  (a_nxt),
        .b_next  (b_nxt),
        .k_next  (k_nxt),
        .done    (step_done),
        .gcd_val (gcd_val)
    );

    // Iteration counter value including the current step, saturating.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Ready is masked by reset so nothing looks acceptable while reset is high.
    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    // Control FSM plus operand, counter and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_gcd    <= '0;
            out_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        k_q   <= '0;
                        cnt_q <= '0;
                        if (in_a == '0 || in_b == '0) begin
                            // A zero operand short-circuits: gcd(x, 0) = x.
                            out_gcd    <= in_a | in_b;
                            out_cycles <= '0;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_inc;
                    if (step_done) begin
                        out_gcd    <= gcd_val;
                        out_cycles <= cnt_inc;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        a_q <= a_nxt;
                        b_q <= b_nxt;
                        k_q <= k_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed vectors with hand-computed
// results, handshake/backpressure/reset scenarios, and random pairs checked
// against a Euclid reference.
module tb_gcd_core;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int EW = 1 + DW + CW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_gcd;
    logic [CW-1:0] out_cycles;
    logic          busy;

    int n_vectors   = 0;
    int n_checks    = 0;
    int miscompares = 0;
    int cyc         = 0;
    int accept_cyc  = 0;
    logic prev_valid = 1'b0;

    // Entry: {check exact cycles, expected gcd, expected cycles}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] head;

    gcd_core #(
        .DATA_WIDTH (DW),
        .CYCLE_W    (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_cycles (out_cycles),
        .busy       (busy)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vectors, miscompares);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW-1:0] t;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Driver: present an operand pair and wait (bounded) for it to be accepted.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] eg, input logic [CW-1:0] ec,
                        input bit chk_cyc, input bit push);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
                accept_cyc = cyc;
                n_vectors++;
                if (push) exp_q.push_back({chk_cyc, eg, ec});
            end else begin
                @(negedge clock);
            end
        end
        if (!ok) begin
            n_checks++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready never high for a=0x%0h b=0x%0h", a, b);
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    // Wait (bounded) at negedges until out_valid is seen.
    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else @(negedge clock);
        end
        if (!seen) begin
            n_checks++;
            miscompares++;
            $display("FAIL %s: out_valid never rose, got 0 expected 1", name);
        end
    endtask

    // Called at the negedge where out_valid && out_ready; checks the idle return.
    task automatic finish_handshake(input string name);
        @(negedge clock);
        check({name, "_in_ready_after"}, in_ready, 1);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_valid_after"}, out_valid, 0);
    endtask

    task automatic run_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] eg, input logic [CW-1:0] ec, input string name);
        send(a, b, eg, ec, 1'b1, 1'b1);
        wait_valid(name);
        finish_handshake(name);
    endtask

    // Monitor / scoreboard: latency on out_valid rise, data on handshake.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    miscompares++;
                    $display("FAIL unexpected_out_valid: got gcd 0x%0h with nothing pending", out_gcd);
                end else begin
                    head = exp_q[0];
                    if (head[EW-1]) check("latency", cyc - accept_cyc, head[CW-1:0]);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                check("out_gcd", out_gcd, head[EW-2:CW]);
                if (head[EW-1]) check("out_cycles", out_cycles, head[CW-1:0]);
                else check("out_cycles_bound", out_cycles <= 16'(3 * DW), 1);
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        int m;

        // Reset, with in_valid asserted to show reset wins
        reset = 1'b1;
        in_valid = 1'b1;
        in_a = 32'd12;
        in_b = 32'd18;
        repeat (3) @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_gcd", out_gcd, 0);
        check("rst_out_cycles", out_cycles, 0);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check("post_rst_busy", busy, 0);
        check("post_rst_in_ready", in_ready, 1);

        // Directed vectors
        run_vec(32'd12, 32'd18, 32'd6, 16'd5, "g12_18");
        run_vec(32'd7, 32'd7, 32'd7, 16'd1, "g7_7");
        run_vec(32'd0, 32'd5, 32'd5, 16'd0, "g0_5");
        run_vec(32'd5, 32'd0, 32'd5, 16'd0, "g5_0");
        run_vec(32'd0, 32'd0, 32'd0, 16'd0, "g0_0");
        run_vec(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 16'd32, "g_big");
        run_vec(32'd48, 32'd18, 32'd6, 16'd7, "g48_18");
        run_vec(32'd21, 32'd14, 32'd7, 16'd4, "g21_14");

        // Backpressure: result held 3 cycles; stray in_valid during CALC ignored
        out_ready = 1'b0;
        send(32'd12, 32'd18, 32'd6, 16'd5, 1'b1, 1'b1);
        in_valid = 1'b1;
        in_a = 32'd99;
        in_b = 32'd33;
        repeat (3) @(negedge clock);
        in_valid = 1'b0;
        wait_valid("hold");
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", out_valid, 1);
            check("hold_gcd", out_gcd, 6);
            check("hold_cycles", out_cycles, 5);
            check("hold_in_ready", in_ready, 0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        finish_handshake("hold");

        // Reset during the third CALC cycle discards the result
        send(32'd12, 32'd18, 32'd0, 16'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_gcd", out_gcd, 0);
        check("midrst_cycles", out_cycles, 0);
        check("midrst_in_ready", in_ready, 0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("midrst_no_valid", out_valid, 0);
        run_vec(32'd21, 32'd14, 32'd7, 16'd4, "after_rst");

        // Random pairs against Euclid; cycle count only bounded
        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 0) begin
                ra = $urandom;
                rb = $urandom;
            end else begin
                m = $urandom_range(1, 64);
                ra = $urandom_range(1, 2000) * m;
                rb = $urandom_range(1, 2000) * m;
            end
            send(ra, rb, ref_gcd(ra, rb), 16'd0, 1'b0, 1'b1);
            wait_valid("rand");
            finish_handshake("rand");
        end

        repeat (5) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_core.md
# gcd_core

Iterative binary (Stein) GCD engine for the GCD IP. It sits directly downstream of the AXI4-Lite slave register file. It accepts an operand pair via a valid/ready handshake and computes gcd(a, b) over multiple cycles. It returns the result and an iteration count via a second valid/ready handshake, which the register file exposes as result/status registers.

## Interface
- DATA_WIDTH, 32, operand and result width.
- CYCLE_W, 16, width of iteration counter.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  core idle and able to accept.
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_gcd  out  DATA_WIDTH  gcd(a, b).
- out_cycles  out  CYCLE_W  number of CALC cycles used; saturates at 2^CYCLE_W-1.
- busy  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE.
- in_ready = (state == IDLE). busy = (state != IDLE).
- Accept occurs when in_valid && in_ready. On accept, latch a = in_a, b = in_b, k = 0, cnt = 0.
  - If a == 0 or b == 0: out_gcd = a | b, out_cycles = 0, go to DONE directly. This gives gcd(0,0) = 0.
  - Otherwise go to CALC.
- CALC performs one step per cycle and increments cnt (saturating). The first matching rule applies:
  1. a == b: out_gcd = a << k, out_cycles = cnt+1, go to DONE.
  2. a and b both even: a >>= 1, b >>= 1, k += 1.
  3. a even: a >>= 1.
  4. b even: b >>= 1.
  5. a > b: a = a − b.
  6. Otherwise: b = b − a.
- Arithmetic rules:
  - Subtraction only occurs on unequal odd values, so the result is positive and never underflows.
  - a and b never reach 0 in CALC.
  - k ≤ DATA_WIDTH−1, width $clog2(DATA_WIDTH).
  - a << k never overflows, since the true gcd ≤ min(in_a, in_b).
- DONE: out_valid = 1 with out_gcd and out_cycles stable. When out_ready, go to IDLE. There is no same-cycle re-accept; in_ready rises the cycle after the output handshake.
- in_valid, in_a and in_b are ignored while busy.

## Timing
- Reset values:
  - in_ready = 0 while reset is high, then 1.
  - out_valid = 0, busy = 0, out_gcd = 0, out_cycles = 0.
  - Internal a, b, k and cnt are cleared.
- Latency: out_valid rises on the N-th rising edge after the accepting edge, where N = out_cycles. For N = 0 (zero operand), out_valid rises on the accepting edge itself.
- Throughput: one result per N+2 cycles minimum, given out_ready held high.
- out_valid stays high, and outputs stay stable, for any number of cycles with out_ready low.
- Reset mid-CALC or mid-DONE: next cycle is IDLE with outputs at reset values. The in-flight result is discarded and no out_valid pulse occurs.
- Asserting in_valid and reset together: reset wins; nothing is accepted.

## Structure
- Shared package gcd_pkg holds:
  - state enum typedef gcd_state_t {IDLE, CALC, DONE};
  - default DATA_WIDTH / CYCLE_W constants;
  - shift-counter width function.
  - The register-file slave also imports it for the status encoding.
- One natural sub-module, gcd_step. It is purely combinational: from (a, b, k) it produces next (a, b, k) and a done flag, implementing rules 1–6.
- gcd_core holds the FSM, registers, handshake logic and counter.

## Test plan
- gcd(12, 18) with out_ready = 1 → out_gcd = 6, out_cycles = 5, out_valid on 5th edge after accept; in_ready returns 1 the cycle after the handshake.
- gcd(7, 7) → 7, out_cycles = 1. gcd(0, 5) → 5, out_cycles = 0, out_valid on the accept edge. gcd(0, 0) → 0.
- gcd(0x80000000, 0x40000000) → 0x40000000, out_cycles = 32. This checks k = 30 and shift-back with no overflow.
- gcd(12, 18) with out_ready low for 3 cycles after out_valid → outputs stable, in_ready = 0 throughout. A new in_valid pulse during CALC/DONE is not accepted.
- Reset asserted on the 3rd CALC cycle of gcd(12, 18) → IDLE next cycle, no out_valid. A subsequent gcd(21, 14) → 7.
- Random 200 pairs vs. reference Euclid model → all out_gcd match, and out_cycles ≤ 3·DATA_WIDTH.
